// File: rtl/regfile_host_arbiter.sv
// rtl/regfile_host_arbiter.sv - shares the register file write port and read port 1 between the WB stage and a host requester
module regfile_host_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 3,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              pipe_stall,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              pipe_wena,
    input  logic [ADDR_W-1:0] pipe_r1addr,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_r1addr,
    input  logic [DATA_W-1:0] rf_r1data,
    output logic              wr_conflict
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                host_slot;
    logic                commit;

    // The host only owns the ports in ACCESS cycles where the WB stage is idle.
    assign host_slot  = (state_q == ACCESS) && !pipe_wena;
    assign commit     = host_slot;
    assign pipe_stall = (state_q == DRAIN) || (state_q == ACCESS);
    assign host_ack   = (state_q == RESP);

    always_comb begin
        rf_wena   = pipe_wena;
        rf_waddr  = pipe_waddr;
        rf_wdata  = pipe_wdata;
        rf_r1addr = pipe_r1addr;
        if (host_slot) begin
            rf_wena   = lat_we;
            rf_waddr  = lat_addr;
            rf_wdata  = lat_wdata;
            rf_r1addr = lat_addr;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (host_req) begin
                    state_d = DRAIN;
                    cnt_d   = CNT_INIT;
                end
            end
            DRAIN: begin
                if (!host_req) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0 && !pipe_wena) begin
                    state_d = ACCESS;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACCESS: begin
                if (commit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (!host_req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state_q == IDLE && host_req) begin
            lat_we    <= host_we;
            lat_addr  <= host_addr;
            lat_wdata <= host_wdata;
        end
    end

    // Read data persists across later writes; only a committed read replaces it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            host_rdata <= '0;
        end else if (commit && !lat_we) begin
            host_rdata <= rf_r1data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_conflict <= 1'b0;
        end else if (state_q == ACCESS && pipe_wena) begin
            wr_conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_host_arbiter.sv
// tb/tb_regfile_host_arbiter.sv - randomized transaction-level check of regfile_host_arbiter
module tb_regfile_host_arbiter;

    localparam int D = 4;

    logic        clk;
    logic        clr_n;
    logic        host_req;
    logic        host_we;
    logic [2:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;
    logic        pipe_stall;
    logic [2:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        pipe_wena;
    logic [2:0]  pipe_r1addr;
    logic [2:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_wena;
    logic [2:0]  rf_r1addr;
    logic [31:0] rf_r1data;
    logic        wr_conflict;

    logic [31:0] rf_mem [8];
    logic [31:0] model  [8];
    logic [31:0] exp_rdata;
    logic        exp_conf;
    int          total;
    int          bad;

    regfile_host_arbiter #(.DATA_W(32), .ADDR_W(3), .DRAIN_CYCLES(D)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_ack    (host_ack),
        .host_rdata  (host_rdata),
        .pipe_stall  (pipe_stall),
        .pipe_waddr  (pipe_waddr),
        .pipe_wdata  (pipe_wdata),
        .pipe_wena   (pipe_wena),
        .pipe_r1addr (pipe_r1addr),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_wena     (rf_wena),
        .rf_r1addr   (rf_r1addr),
        .rf_r1data   (rf_r1data),
        .wr_conflict (wr_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wena) rf_mem[rf_waddr] <= rf_wdata;
    end
    assign rf_r1data = rf_mem[rf_r1addr];

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) check(tag, rf_mem[i], model[i]);
    endtask

    // pre: WB writes on the first pre edges after the request; conf: WB writes during ACCESS
    task automatic txn(input logic we, input logic [2:0] addr, input logic [31:0] data,
                       input int pre, input int conf);
        logic        mask [0:63];
        logic [2:0]  wa   [0:63];
        logic [31:0] wd   [0:63];
        int k, c, ack_at, stalls;
        for (int i = 0; i < 64; i++) begin
            mask[i] = 1'b0;
            wa[i]   = 3'($urandom);
            wd[i]   = $urandom;
        end
        for (int i = 1; i <= pre; i++) mask[i] = 1'b1;
        k = D;
        while (mask[k]) k++;
        for (int i = 1; i <= conf; i++) mask[k + i] = 1'b1;
        c = k + 1;
        while (mask[c]) c++;
        for (int j = 1; j <= c; j++) begin
            if (mask[j]) model[wa[j]] = wd[j];
            if (j == c) begin
                if (we) model[addr] = data;
                else    exp_rdata   = model[addr];
            end
        end
        if (conf > 0) exp_conf = 1'b1;

        @(negedge clk);
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = data;
        pipe_wena  = 1'b0;
        ack_at = -1;
        stalls = 0;
        for (int j = 1; j < 64; j++) begin
            @(negedge clk);
            if (host_ack) begin
                ack_at = j - 1;
                break;
            end
            stalls += int'(pipe_stall);
            pipe_wena   = mask[j];
            pipe_waddr  = wa[j];
            pipe_wdata  = wd[j];
            pipe_r1addr = 3'($urandom);
            host_we     = 1'($urandom);
            host_addr   = 3'($urandom);
            host_wdata  = $urandom;
            if (j == c) begin
                #1;
                check("acc_r1addr", 32'(rf_r1addr), 32'(addr));
                check("acc_wena", 32'(rf_wena), 32'(we));
                if (we) begin
                    check("acc_waddr", 32'(rf_waddr), 32'(addr));
                    check("acc_wdata", rf_wdata, data);
                end
            end
        end
        check("ack_edge", 32'(ack_at), 32'(c));
        check("stall_cycles", 32'(stalls), 32'(c));
        check("resp_stall", 32'(pipe_stall), 32'd0);
        check("rdata", host_rdata, exp_rdata);
        check("conflict", 32'(wr_conflict), 32'(exp_conf));
        host_req  = 1'b0;
        pipe_wena = 1'b0;
        @(negedge clk);
        check("ack_release", 32'(host_ack), 32'd0);
        check("rdata_hold", host_rdata, exp_rdata);
        check_rf("rf_contents");
    endtask

    task automatic reset_during(input int n_neg, input logic [2:0] addr);
        @(negedge clk);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = addr;
        host_wdata = ~model[addr];
        for (int j = 1; j <= n_neg; j++) @(negedge clk);
        #1;
        clr_n = 1'b0;
        #1;
        check("rst_stall", 32'(pipe_stall), 32'd0);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_wena", 32'(rf_wena), 32'd0);
        check("rst_rdata", host_rdata, 32'd0);
        check("rst_conflict", 32'(wr_conflict), 32'd0);
        host_req = 1'b0;
        exp_rdata = 32'd0;
        exp_conf  = 1'b0;
        #1;
        clr_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_idle_stall", 32'(pipe_stall), 32'd0);
        check_rf("rst_rf");
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_rdata = 32'd0;
        exp_conf = 1'b0;
        clr_n = 1'b0;
        host_req = 1'b0;
        host_we = 1'b0;
        host_addr = 3'd0;
        host_wdata = 32'd0;
        pipe_waddr = 3'd0;
        pipe_wdata = 32'd0;
        pipe_wena = 1'b0;
        pipe_r1addr = 3'd0;
        #12;
        check("reset_stall", 32'(pipe_stall), 32'd0);
        check("reset_ack", 32'(host_ack), 32'd0);
        check("reset_rdata", host_rdata, 32'd0);
        check("reset_conflict", 32'(wr_conflict), 32'd0);
        check("reset_wena", 32'(rf_wena), 32'd0);
        clr_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pipe_wena  = 1'b1;
            pipe_waddr = 3'(i);
            pipe_wdata = $urandom;
            model[i]   = pipe_wdata;
        end
        @(negedge clk);
        pipe_wena = 1'b0;
        @(negedge clk);
        check_rf("init_rf");

        txn(1'b1, 3'd5, 32'hDEADBEEF, 0, 0);
        txn(1'b0, 3'd5, 32'd0, 0, 0);
        check("read_back", host_rdata, 32'hDEADBEEF);
        txn(1'b1, 3'd2, 32'h0000_0011, 6, 0);
        check("drain_noconf", 32'(wr_conflict), 32'd0);
        txn(1'b1, 3'd3, 32'hCAFE_F00D, 0, 2);
        txn(1'b0, 3'd3, 32'd0, 2, 0);

        @(negedge clk);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 3'd6;
        host_wdata = ~model[6];
        @(negedge clk);
        @(negedge clk);
        host_req = 1'b0;
        #1;
        check("abort_wena", 32'(rf_wena), 32'd0);
        @(negedge clk);
        check("abort_stall", 32'(pipe_stall), 32'd0);
        check("abort_ack", 32'(host_ack), 32'd0);
        @(negedge clk);
        check("abort_ack2", 32'(host_ack), 32'd0);
        check_rf("abort_rf");

        for (int n = 0; n < 30; n++) begin
            txn(1'($urandom), 3'($urandom), $urandom,
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        reset_during(3, 3'd7);
        reset_during(5, 3'd1);
        txn(1'b0, 3'd1, 32'd0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
